if_stage: RTL

Instruction-fetch stage of the LC-3b pipeline. It sits directly upstream of the decode stage. It owns the PC and the instruction-memory read handshake, and it drives the IF/ID pipeline register that decode consumes as its instruction word. It honours a decode stall and a redirect (taken branch, jump or trap) from later stages. An in-flight memory read is never abandoned mid-handshake.

---
 rtl/if_stage_pkg.sv | 12 +
 rtl/if_stage_if_id_reg.sv | 23 ++
 rtl/if_stage.sv | 72 +++++++
 3 files changed

// File: rtl/if_stage_pkg.sv
// if_stage_pkg: shared LC-3b fetch types and the PC+2 helper.
package if_stage_pkg;
   typedef logic [15:0] lc3b_word;
   typedef struct packed {
      logic     valid;
      lc3b_word inst;
      lc3b_word pc;
   } lc3b_if_id_reg;
   function automatic lc3b_word plus2(lc3b_word a);
      return a + 16'd2;
   endfunction
endpackage

// File: rtl/if_stage_if_id_reg.sv
// if_id_reg: load / hold / flush pipeline register; flush only kills the valid bit.
module if_id_reg
   import if_stage_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        load,
   input  logic        flush,
   input  logic [15:0] d_inst,
   input  logic [15:0] d_pc,
   output logic        valid,
   output logic [15:0] inst,
   output logic [15:0] pc
);
   lc3b_if_id_reg q;
   always_ff @(posedge clk or posedge reset)
      if (reset) q <= '0;
      else if (flush) q.valid <= 1'b0;
      else if (load) q <= '{valid: 1'b1, inst: d_inst, pc: d_pc};
   assign valid = q.valid;
   assign inst = q.inst;
   assign pc = q.pc;
endmodule

// File: rtl/if_stage.sv
// if_stage: LC-3b instruction fetch with skid buffer, decode stall and redirect;
// an outstanding memory read is always completed before the PC moves.
module if_stage
   import if_stage_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   output logic        mem_read,
   output logic [15:0] mem_address,
   input  logic [15:0] mem_rdata,
   input  logic        mem_resp,
   input  logic        id_stall,
   input  logic        redirect,
   input  logic [15:0] redirect_target,
   output logic        if_id_valid,
   output logic [15:0] if_id_inst,
   output logic [15:0] if_id_pc
);
   typedef enum logic [1:0] {FETCH, FULL, DISCARD} state_t;
   state_t state;
   lc3b_word pc, pc_next, target, pending_target;
   logic accept, id_load, id_flush, buf_load, buf_valid;
   logic [15:0] buf_inst, buf_pc;
   assign target = redirect_target & 16'hFFFE;
   assign pc_next = plus2(pc);
   assign accept = !if_id_valid || !id_stall;
   assign buf_load = state == FETCH && mem_resp && !redirect && !accept;
   assign id_load = !redirect && ((state == FETCH && mem_resp && accept) ||
                                  (state == FULL && buf_valid && !id_stall));
   assign id_flush = redirect || (!id_load && !id_stall);
   assign mem_read = !reset && state != FULL;
   assign mem_address = pc;
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         state <= FETCH;
         pc <= '0;
         pending_target <= '0;
      end else
         case (state)
            FETCH:
               if (redirect && mem_resp) pc <= target;
               else if (redirect) begin
                  pending_target <= target;
                  state <= DISCARD;
               end else if (mem_resp) begin
                  pc <= pc_next;
                  if (!accept) state <= FULL;
               end
            FULL:
               if (redirect) begin
                  pc <= target;
                  state <= FETCH;
               end else if (!id_stall) state <= FETCH;
            DISCARD:
               if (mem_resp) begin
                  pc <= redirect ? target : pending_target;
                  state <= FETCH;
               end else if (redirect) pending_target <= target;
            default: state <= FETCH;
         endcase
   if_id_reg u_skid (
      .clk(clk), .reset(reset), .load(buf_load), .flush(redirect),
      .d_inst(mem_rdata), .d_pc(pc_next),
      .valid(buf_valid), .inst(buf_inst), .pc(buf_pc)
   );
   if_id_reg u_if_id (
      .clk(clk), .reset(reset), .load(id_load), .flush(id_flush),
      .d_inst(state == FULL ? buf_inst : mem_rdata),
      .d_pc(state == FULL ? buf_pc : pc_next),
      .valid(if_id_valid), .inst(if_id_inst), .pc(if_id_pc)
   );
endmodule
